// File: rtl/yduck_gpio_pkg.sv
// rtl/yduck_gpio_pkg.sv - shared constants and debounce state type for GPIO input conditioning
package yduck_gpio_pkg;

    localparam int GPIO_DW            = 16;
    localparam int GPIO_DB_CYCLES_DEF = 8;

    // Debounce state of one bit: IDLE when synchronised level matches the
    // accepted level, PEND while a differing level is being timed.
    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_PEND = 1'b1
    } db_state_e;

endpackage

// File: rtl/gpio_in_cond_if.sv
// rtl/gpio_in_cond_if.sv - pad/level/edge-flag signal bundle for gpio_in_cond
interface gpio_in_cond_if
    import yduck_gpio_pkg::*;
#(
    parameter int DW = GPIO_DW
);

    logic [DW-1:0] pin_in;
    logic [DW-1:0] gpio_in;
    logic [DW-1:0] edge_clr;
    logic [DW-1:0] edge_flag;
    logic          edge_any;

    // Driver side: pads and software clear strobes
    modport master (
        output pin_in,
        output edge_clr,
        input  gpio_in,
        input  edge_flag,
        input  edge_any
    );

    // Conditioning block side
    modport slave (
        input  pin_in,
        input  edge_clr,
        output gpio_in,
        output edge_flag,
        output edge_any
    );

endinterface

// File: rtl/gpio_db_bit.sv
// rtl/gpio_db_bit.sv - one-bit synchroniser, debouncer and optional sticky rise flag (GPIO_EDGE_EN)
module gpio_db_bit
    import yduck_gpio_pkg::*;
#(
    parameter int DB_CYCLES = GPIO_DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    input  logic i_clr,
    output logic o_level,
    output logic o_flag
);

    // Counter only ever reaches DB_CYCLES-1, so $clog2 bits never wrap
    localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_stable_nxt;
    db_state_e     w_state;

    // Two-flop synchroniser for the asynchronous pad level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce decode: state follows from level mismatch, count or accept
    always_comb begin
        w_state      = (r_sync2 == r_stable) ? DB_IDLE : DB_PEND;
        w_cnt_nxt    = '0;
        w_stable_nxt = r_stable;
        case (w_state)
            DB_IDLE: begin
                w_cnt_nxt = '0;
            end
            DB_PEND: begin
                if (r_cnt == CNT_MAX) begin
                    w_stable_nxt = r_sync2;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt    = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Debounce counter and accepted level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    assign o_level = r_stable;

`ifdef GPIO_EDGE_EN
    logic r_flag;
    logic w_rise;

    assign w_rise = ~r_stable & w_stable_nxt;

    // Sticky rise flag: a set on the same edge as a clear takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (w_rise) begin
            r_flag <= 1'b1;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end
    end

    assign o_flag = r_flag;
`else
    logic w_unused_clr;

    assign w_unused_clr = i_clr;
    assign o_flag       = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - GPIO input conditioning top: per-bit sync/debounce, optional edge flags (GPIO_EDGE_EN)
module gpio_in_cond
    import yduck_gpio_pkg::*;
#(
    parameter int DW        = GPIO_DW,
    parameter int DB_CYCLES = GPIO_DB_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    gpio_in_cond_if.slave  bus
);

    logic [DW-1:0] w_level;
    logic [DW-1:0] w_flag;

    // Bits are fully independent, one conditioner each
    for (genvar g = 0; g < DW; g++) begin : g_bit
        gpio_db_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db_bit (
            .clk     (clk),
            .rst     (rst),
            .i_pin   (bus.pin_in[g]),
            .i_clr   (bus.edge_clr[g]),
            .o_level (w_level[g]),
            .o_flag  (w_flag[g])
        );
    end

    assign bus.gpio_in   = w_level;
    assign bus.edge_flag = w_flag;
    assign bus.edge_any  = |w_flag;

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input conditioning stage that sits directly upstream of the SoC `gpio_in` port. It turns raw, asynchronous, possibly bouncing pad levels into clean, clock-synchronous levels. Each bit is synchronised, debounced with a per-bit counter, and optionally captured as a sticky rising-edge flag that software polls and clears.

## Interface
- `DW`, 16, data width; matches the SoC GPIO width.
- `DB_CYCLES`, 8, number of consecutive stable cycles required to accept a new level; legal range 2..65536.
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `pin_in`  input  DW  raw pad levels, asynchronous to `clk`.
- `gpio_in`  output  DW  debounced levels; drives the SoC `gpio_in`.
- `edge_clr`  input  DW  per-bit clear strobe for `edge_flag`.
- `edge_flag`  output  DW  sticky rising-edge flags.
- `edge_any`  output  1  OR-reduction of `edge_flag`.

## Operation
- Every sequential element is updated only on the `clk` rising edge.
- **Reset.** While `rst` is sampled high, all of the following are 0 on the next edge:
  - `sync1`, `sync2`, `stable` (which is `gpio_in`), every counter, `edge_flag` and `edge_any`.
- **Synchronisation.** Two-flop synchroniser per bit: `sync1` <= `pin_in`, then `sync2` <= `sync1`.
- **Debounce, per bit.** Two states, derived from `sync2 == stable`:
  - **IDLE** (`sync2 == stable`): counter <= 0.
  - **PEND** (`sync2 != stable`), counter below `DB_CYCLES-1`: counter increments.
  - **PEND**, counter equal to `DB_CYCLES-1`: `stable` <= `sync2` and counter <= 0.
- **Glitch rejection.** A mismatch that lasts fewer than `DB_CYCLES` consecutive `sync2` cycles returns the bit to IDLE. The counter resets and `stable` is unchanged.
- **Counter width.** `$clog2(DB_CYCLES)`, unsigned. The counter never wraps, because it is cleared at `DB_CYCLES-1`.
- **Edge flags, per bit:**
  - The flag is set on the same edge on which `stable` goes 0->1.
  - It is cleared on any edge where `edge_clr` is high and no set occurs.
  - Set and clear on the same edge: set wins, and the flag stays 1.
  - A 1->0 transition of `stable` does not affect the flag.
- **`edge_any`.** Combinational OR of the registered `edge_flag` bits. It has no extra latency.
- **Bit independence.** Bits are fully independent. There is no cross-bit interaction.

## Timing
- **Acceptance latency.** A level change sampled into `sync1` at edge k appears on `gpio_in` after edge k+1+`DB_CYCLES`.
  - That is `DB_CYCLES`+2 edges, including the sampling edge.
  - With the default `DB_CYCLES` = 8 this is 10 edges.
- **Edge flag timing.** `edge_flag` rises on the same edge as `gpio_in`. A clear takes effect on the edge that samples `edge_clr` high.
- **Reset mid-count.** The partial count is discarded. A level held after reset deasserts needs the full `DB_CYCLES`+2 edges, counted from the first edge with `rst` low.
- **Reset before reset.** Before the first reset, output values are undefined; the bench must reset first.

## Configuration
- Macro: `GPIO_EDGE_EN`.
- **Defined:** the edge-flag logic, `edge_clr` handling and `edge_any` are compiled in as described above.
- **Undefined:**
  - No flag registers are generated.
  - `edge_flag` is tied to 0 and `edge_any` is tied to 0.
  - `edge_clr` is ignored.
  - Debounce behaviour and latency are unchanged.

## Structure
- **Package `yduck_gpio_pkg`:**
  - `GPIO_DW` = 16 and `GPIO_DB_CYCLES_DEF` = 8.
  - The debounce state enum `db_state_e` with members `DB_IDLE` and `DB_PEND`.
- **Sub-module `gpio_db_bit`:**
  - Contains the synchroniser, counter, stable register and optional flag for one bit.
  - `gpio_in_cond` instantiates it `DW` times in a generate loop and ORs the flags into `edge_any`.

## Test plan
- **Reset:** hold `rst` = 1 for 3 cycles with `pin_in` = 16'hFFFF -> during and after reset, `gpio_in` = 0, `edge_flag` = 0 and `edge_any` = 0.
- **Step input:** after reset, set `pin_in` = 16'hFA1C and hold it -> `gpio_in` stays 0 through edge 9 and equals 16'hFA1C after edge 10. `edge_flag` = 16'hFA1C and `edge_any` = 1 on that same edge.
- **Glitch rejection:** pulse `pin_in[0]` high for 7 cycles, then low -> `gpio_in[0]` stays 0 and `edge_flag[0]` stays 0. Repeat with an 8-cycle pulse -> `gpio_in[0]` goes to 1.
- **Clear:**
  - With `edge_flag` = 16'hFA1C, pulse `edge_clr` = 16'h0010 for one cycle -> `edge_flag` = 16'hFA0C.
  - Pulse `edge_clr` = 16'hFFFF -> `edge_flag` = 0 and `edge_any` = 0.
- **Set-wins:** assert `edge_clr[1]` on the exact edge where `gpio_in[1]` goes 0->1 -> `edge_flag[1]` = 1.
- **Reset mid-count:** assert `rst` for 1 cycle 5 edges after `pin_in` rises -> `gpio_in` rises exactly 10 edges after the first edge with `rst` low.
